efb_wb_arbiter: RTL and testbench

- Shares the single WISHBONE slave port of the MachXO2 EFB (SPI registers 0x59 SPITXDR, 0x5A SPISR, 0x5B SPIRXDR, plus SPI config registers) between two requesters.
- Requester A is the SPI RX poller and requester B is the SPI TX/config writer.
- Performs one WISHBONE single-beat transaction at a time, with round-robin arbitration and a registered result hand-back.
- Sits between the SPI front-end logic and the EFB primitive.

---
 rtl/efb_wb_arbiter_if.sv | 21 ++
 rtl/efb_wb_arbiter.sv | 151 +++++++++++++++
 tb/tb_efb_wb_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/efb_wb_arbiter_if.sv
// WISHBONE link between the arbiter (master) and the MachXO2 EFB slave port.
// Signal names follow the EFB primitive: *_i are EFB inputs, *_o are EFB outputs.
interface efb_wb_arbiter_if;
    logic       wb_cyc_i;
    logic       wb_stb_i;
    logic       wb_we_i;
    logic [7:0] wb_adr_i;
    logic [7:0] wb_dat_i;
    logic [7:0] wb_dat_o;
    logic       wb_ack_o;

    modport master (
        output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i,
        input  wb_dat_o, wb_ack_o
    );

    modport slave (
        input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i,
        output wb_dat_o, wb_ack_o
    );
endinterface

// File: rtl/efb_wb_arbiter.sv
// Two-requester round-robin arbiter in front of the EFB WISHBONE slave, one single-beat
// transaction at a time. Optional bus timeout enabled by defining WB_TIMEOUT_EN.
module efb_wb_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned CNT_W          = 8
) (
    input  logic                    IO_main_clk,
    input  logic                    IO_rst_n,
    input  logic                    a_req,
    input  logic                    a_we,
    input  logic [7:0]              a_adr,
    input  logic [7:0]              a_wdat,
    output logic                    a_done,
    output logic                    a_err,
    input  logic                    b_req,
    input  logic                    b_we,
    input  logic [7:0]              b_adr,
    input  logic [7:0]              b_wdat,
    output logic                    b_done,
    output logic                    b_err,
    output logic [7:0]              rdat,
    efb_wb_arbiter_if.master        wb
);

    typedef enum logic [1:0] {IDLE, BUS, HOLD} state_e;

    state_e     state_q, state_d;
    // Holds the current grant while in BUS and doubles as last_grant otherwise.
    logic       gnt_b_q, gnt_b_d;
    logic       cyc_q, cyc_d;
    logic       we_q, we_d;
    logic [7:0] adr_q, adr_d;
    logic [7:0] dat_q, dat_d;
    logic [7:0] rdat_q, rdat_d;
    logic       a_done_q, a_done_d;
    logic       b_done_q, b_done_d;
    logic       err_q, err_d;

    logic any_req, sel_b, fin_ok, fin_tmo;

    assign any_req = a_req | b_req;
    assign sel_b   = b_req & (~a_req | ~gnt_b_q);
    assign fin_ok  = (state_q == BUS) & wb.wb_ack_o;

`ifdef WB_TIMEOUT_EN
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign fin_tmo = (state_q == BUS) & ~wb.wb_ack_o & (cnt_q == CNT_LAST);

    // Cleared while idle so every BUS phase starts counting from zero.
    always_comb begin
        cnt_d = cnt_q;
        if (state_q == IDLE)
            cnt_d = '0;
        else if (state_q == BUS && !wb.wb_ack_o)
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge IO_main_clk or negedge IO_rst_n) begin
        if (!IO_rst_n) cnt_q <= '0;
        else           cnt_q <= cnt_d;
    end
`else
    logic [CNT_W-1:0] unused_tmo;

    assign fin_tmo    = 1'b0;
    assign unused_tmo = CNT_W'(TIMEOUT_CYCLES);
`endif

    always_ff @(posedge IO_main_clk or negedge IO_rst_n) begin
        if (!IO_rst_n) state_q <= IDLE;
        else           state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (any_req) state_d = BUS;
            BUS:     if (fin_ok || fin_tmo) state_d = HOLD;
            HOLD:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        gnt_b_d  = gnt_b_q;
        cyc_d    = cyc_q;
        we_d     = we_q;
        adr_d    = adr_q;
        dat_d    = dat_q;
        rdat_d   = rdat_q;
        a_done_d = 1'b0;
        b_done_d = 1'b0;
        err_d    = 1'b0;
        case (state_q)
            IDLE: if (any_req) begin
                gnt_b_d = sel_b;
                cyc_d   = 1'b1;
                we_d    = sel_b ? b_we   : a_we;
                adr_d   = sel_b ? b_adr  : a_adr;
                dat_d   = sel_b ? b_wdat : a_wdat;
            end
            BUS: if (fin_ok || fin_tmo) begin
                cyc_d    = 1'b0;
                rdat_d   = fin_ok ? wb.wb_dat_o : 8'hFF;
                a_done_d = ~gnt_b_q;
                b_done_d = gnt_b_q;
                err_d    = ~fin_ok;
            end
            default: ;
        endcase
    end

    always_ff @(posedge IO_main_clk or negedge IO_rst_n) begin
        if (!IO_rst_n) begin
            gnt_b_q  <= 1'b1;
            cyc_q    <= 1'b0;
            we_q     <= 1'b0;
            adr_q    <= 8'h00;
            dat_q    <= 8'h00;
            rdat_q   <= 8'h00;
            a_done_q <= 1'b0;
            b_done_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            gnt_b_q  <= gnt_b_d;
            cyc_q    <= cyc_d;
            we_q     <= we_d;
            adr_q    <= adr_d;
            dat_q    <= dat_d;
            rdat_q   <= rdat_d;
            a_done_q <= a_done_d;
            b_done_q <= b_done_d;
            err_q    <= err_d;
        end
    end

    assign wb.wb_cyc_i = cyc_q;
    assign wb.wb_stb_i = cyc_q;
    assign wb.wb_we_i  = we_q;
    assign wb.wb_adr_i = adr_q;
    assign wb.wb_dat_i = dat_q;
    assign rdat        = rdat_q;
    assign a_done      = a_done_q;
    assign b_done      = b_done_q;
    assign a_err       = err_q & a_done_q;
    assign b_err       = err_q & b_done_q;

endmodule

// File: tb/tb_efb_wb_arbiter.sv
// Bench for efb_wb_arbiter: transaction-level reference model checked every cycle,
// plus directed scenarios with literal expectations (timeout cases need WB_TIMEOUT_EN).
module tb_efb_wb_arbiter;
    localparam int TMO = 4;

    typedef struct {
        logic       we;
        logic [7:0] adr;
        logic [7:0] dat;
    } txn_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0;
    logic [7:0] a_adr = 8'h00, a_wdat = 8'h00, b_adr = 8'h00, b_wdat = 8'h00;
    logic       a_done, a_err, b_done, b_err;
    logic [7:0] rdat;
    logic       rsp_ack = 1'b0, stray_ack = 1'b0;
    logic [7:0] rsp_dat = 8'h00;
    int         ack_dly = 1;   // BUS cycle on which the EFB acks; 0 = never

    int n_cmp = 0;
    int n_bad = 0;

    txn_t aq[$];
    txn_t bq[$];

    always #5 clk = ~clk;

    efb_wb_arbiter_if wb();
    assign wb.wb_ack_o = rsp_ack | stray_ack;
    assign wb.wb_dat_o = rsp_dat;

    efb_wb_arbiter #(.TIMEOUT_CYCLES(TMO), .CNT_W(8)) dut (
        .IO_main_clk(clk), .IO_rst_n(rst_n),
        .a_req(a_req), .a_we(a_we), .a_adr(a_adr), .a_wdat(a_wdat), .a_done(a_done), .a_err(a_err),
        .b_req(b_req), .b_we(b_we), .b_adr(b_adr), .b_wdat(b_wdat), .b_done(b_done), .b_err(b_err),
        .rdat(rdat), .wb(wb)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Requesters: present queue head, retire it when done is seen, keep req up if more remain.
    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            a_req = 1'b0;
            b_req = 1'b0;
        end else begin
            if (a_req && a_done) void'(aq.pop_front());
            if (b_req && b_done) void'(bq.pop_front());
            if (aq.size() > 0) begin
                a_req = 1'b1; a_we = aq[0].we; a_adr = aq[0].adr; a_wdat = aq[0].dat;
            end else a_req = 1'b0;
            if (bq.size() > 0) begin
                b_req = 1'b1; b_we = bq[0].we; b_adr = bq[0].adr; b_wdat = bq[0].dat;
            end else b_req = 1'b0;
        end
    end

    // EFB responder: ack on the ack_dly-th cycle of cyc.
    initial begin
        int n;
        n = 0;
        forever begin
            @(negedge clk);
            if (wb.wb_cyc_i && !rsp_ack) begin
                n++;
                rsp_ack = (ack_dly != 0 && n == ack_dly);
            end else begin
                n = 0;
                rsp_ack = 1'b0;
            end
        end
    end

    // Bus monitor: grant order, idle gap between grants, length of the last cyc burst.
    logic [7:0] glog[$];
    int gap = 100, min_gap = 100, bus_len = 0, last_len = 0;
    logic cyc_prev = 1'b0;
    initial forever begin
        @(negedge clk);
        if (wb.wb_cyc_i && !cyc_prev) begin
            glog.push_back(wb.wb_adr_i);
            if (gap < min_gap) min_gap = gap;
            bus_len = 0;
        end
        if (wb.wb_cyc_i) bus_len++;
        else if (cyc_prev) begin last_len = bus_len; gap = 1; end
        else gap++;
        cyc_prev = wb.wb_cyc_i;
    end

    // Reference model: one transaction in flight, a cool-down cycle after each completion.
    function automatic int pick(input logic ra, input logic rb, input int last);
        if (ra && rb) return (last == 1) ? 2 : 1;
        return ra ? 1 : 2;
    endfunction

    logic       m_cyc, m_we, m_err, m_cool;
    logic [7:0] m_adr, m_dat, m_rdat;
    int         m_done, m_who, m_last, m_age, m_pick;

    assign m_pick = pick(a_req, b_req, m_last);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cyc <= 1'b0; m_we <= 1'b0; m_adr <= 8'h00; m_dat <= 8'h00; m_rdat <= 8'h00;
            m_done <= 0; m_err <= 1'b0; m_who <= 0; m_last <= 2; m_age <= 0; m_cool <= 1'b0;
        end else begin
            m_done <= 0;
            m_err  <= 1'b0;
            m_cool <= 1'b0;
            if (m_cyc) begin
                if (wb.wb_ack_o) begin
                    m_cyc <= 1'b0; m_rdat <= wb.wb_dat_o; m_done <= m_who; m_cool <= 1'b1;
                end
`ifdef WB_TIMEOUT_EN
                else if (m_age + 1 == TMO) begin
                    m_cyc <= 1'b0; m_rdat <= 8'hFF; m_done <= m_who; m_err <= 1'b1; m_cool <= 1'b1;
                end
`endif
                else m_age <= m_age + 1;
            end else if (!m_cool && (a_req || b_req)) begin
                m_cyc  <= 1'b1;
                m_age  <= 0;
                m_who  <= m_pick;
                m_last <= m_pick;
                m_we   <= (m_pick == 1) ? a_we   : b_we;
                m_adr  <= (m_pick == 1) ? a_adr  : b_adr;
                m_dat  <= (m_pick == 1) ? a_wdat : b_wdat;
            end
        end
    end

    initial forever begin
        @(negedge clk);
        chk("cyc", 32'(wb.wb_cyc_i), 32'(m_cyc));
        chk("stb", 32'(wb.wb_stb_i), 32'(m_cyc));
        chk("we", 32'(wb.wb_we_i), 32'(m_we));
        chk("adr", 32'(wb.wb_adr_i), 32'(m_adr));
        chk("wdat", 32'(wb.wb_dat_i), 32'(m_dat));
        chk("a_done", 32'(a_done), 32'(m_done == 1));
        chk("b_done", 32'(b_done), 32'(m_done == 2));
        chk("a_err", 32'(a_err), 32'(m_err && m_done == 1));
        chk("b_err", 32'(b_err), 32'(m_err && m_done == 2));
        if (m_done != 0) chk("rdat", 32'(rdat), 32'(m_rdat));
    end

    task automatic wait_done();
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (a_done || b_done) return;
        end
        chk("wait_done_expired", 32'd0, 32'd1);
    endtask

    task automatic wait_cyc();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (wb.wb_cyc_i) return;
        end
        chk("wait_cyc_expired", 32'd0, 32'd1);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (aq.size() == 0 && bq.size() == 0 && !wb.wb_cyc_i && !a_done && !b_done) begin
                repeat (2) @(negedge clk);
                return;
            end
        end
        chk("wait_idle_expired", 32'd0, 32'd1);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_cyc", 32'(wb.wb_cyc_i), 32'd0);
        chk("rst_adr", 32'(wb.wb_adr_i), 32'd0);
        chk("rst_rdat", 32'(rdat), 32'd0);
        chk("rst_flags", 32'({a_done, b_done, a_err, b_err}), 32'd0);
        rst_n = 1'b1;

        // A reads SPISR, ack on second BUS cycle
        @(negedge clk);
        ack_dly = 2; rsp_dat = 8'h08;
        aq.push_back('{1'b0, 8'h5A, 8'h00});
        wait_done();
        chk("rd_a_done", 32'(a_done), 32'd1);
        chk("rd_b_done", 32'(b_done), 32'd0);
        chk("rd_rdat", 32'(rdat), 32'h08);
        chk("rd_a_err", 32'(a_err), 32'd0);
        chk("rd_adr", 32'(wb.wb_adr_i), 32'h5A);
        chk("rd_we", 32'(wb.wb_we_i), 32'd0);
        @(negedge clk);
        chk("rd_pulse_len", 32'(a_done), 32'd0);
        chk("rd_len", 32'(last_len), 32'd2);
        wait_idle();

        // B writes SPITXDR, ack on first BUS cycle; rdat still captures the bus data
        ack_dly = 1; rsp_dat = 8'hC3;
        bq.push_back('{1'b1, 8'h59, 8'h3C});
        wait_done();
        chk("wr_b_done", 32'(b_done), 32'd1);
        chk("wr_a_done", 32'(a_done), 32'd0);
        chk("wr_we", 32'(wb.wb_we_i), 32'd1);
        chk("wr_dat", 32'(wb.wb_dat_i), 32'h3C);
        chk("wr_rdat", 32'(rdat), 32'hC3);
        wait_idle();

        // simultaneous requests, two each: A,B,A,B with idle gaps
        glog.delete(); min_gap = 100; rsp_dat = 8'h11;
        aq.push_back('{1'b0, 8'h5B, 8'h00}); aq.push_back('{1'b0, 8'h5A, 8'h00});
        bq.push_back('{1'b1, 8'h59, 8'h11}); bq.push_back('{1'b1, 8'h70, 8'h22});
        wait_idle();
        chk("tie_cnt", 32'(glog.size()), 32'd4);
        if (glog.size() == 4) begin
            chk("tie_g0", 32'(glog[0]), 32'h5B);
            chk("tie_g1", 32'(glog[1]), 32'h59);
            chk("tie_g2", 32'(glog[2]), 32'h5A);
            chk("tie_g3", 32'(glog[3]), 32'h70);
        end
        chk("tie_gap", 32'(min_gap >= 2), 32'd1);

        // B arrives while A is on the bus; A re-requests at once but B goes next
        glog.delete(); ack_dly = 3;
        aq.push_back('{1'b0, 8'h5B, 8'h00}); aq.push_back('{1'b0, 8'h5A, 8'h00});
        wait_cyc();
        bq.push_back('{1'b0, 8'h57, 8'h00});
        wait_idle();
        chk("rr_cnt", 32'(glog.size()), 32'd3);
        if (glog.size() == 3) begin
            chk("rr_g0", 32'(glog[0]), 32'h5B);
            chk("rr_g1", 32'(glog[1]), 32'h57);
            chk("rr_g2", 32'(glog[2]), 32'h5A);
        end

        // ack while idle must not start or end anything
        stray_ack = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("stray_cyc", 32'(wb.wb_cyc_i), 32'd0);
            chk("stray_done", 32'({a_done, b_done}), 32'd0);
        end
        stray_ack = 1'b0;

        // reset in the middle of BUS
        ack_dly = 0;
        aq.push_back('{1'b0, 8'h5A, 8'h00});
        wait_cyc();
        @(negedge clk);
        #2 rst_n = 1'b0;
        aq.delete(); bq.delete();
        #1;
        chk("arst_cyc", 32'(wb.wb_cyc_i), 32'd0);
        chk("arst_stb", 32'(wb.wb_stb_i), 32'd0);
        chk("arst_done", 32'({a_done, b_done}), 32'd0);
        repeat (2) @(negedge clk);
        chk("arst_nodone", 32'({a_done, b_done}), 32'd0);
        #2 rst_n = 1'b1;
        glog.delete(); ack_dly = 1;
        @(negedge clk);
        aq.push_back('{1'b0, 8'h5B, 8'h00});
        bq.push_back('{1'b0, 8'h59, 8'h00});
        wait_idle();
        chk("arst_tie_cnt", 32'(glog.size()), 32'd2);
        if (glog.size() == 2) chk("arst_tie_first", 32'(glog[0]), 32'h5B);

`ifdef WB_TIMEOUT_EN
        // EFB never acks: abort after TMO BUS cycles
        ack_dly = 0;
        aq.push_back('{1'b0, 8'h5B, 8'h00});
        wait_done();
        chk("tmo_a_done", 32'(a_done), 32'd1);
        chk("tmo_a_err", 32'(a_err), 32'd1);
        chk("tmo_rdat", 32'(rdat), 32'hFF);
        @(negedge clk);
        chk("tmo_len", 32'(last_len), 32'd4);
        wait_idle();

        // ack lands on the expiry cycle: normal completion
        ack_dly = 4; rsp_dat = 8'h42;
        aq.push_back('{1'b0, 8'h5B, 8'h00});
        wait_done();
        chk("tmo_ack_done", 32'(a_done), 32'd1);
        chk("tmo_ack_err", 32'(a_err), 32'd0);
        chk("tmo_ack_rdat", 32'(rdat), 32'h42);
        @(negedge clk);
        chk("tmo_ack_len", 32'(last_len), 32'd4);
        wait_idle();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, %0d compared", n_cmp);
        $fatal(1);
    end

endmodule
